// File: rtl/gpu_sram_writer_pkg.sv
// Shared definitions for the framebuffer SRAM writer: pixel field widths,
// SRAM idle pin levels and the write-cycle state encoding.
package gpu_sram_writer_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  // SRAM pins that never change while this block owns the bus
  localparam logic SRAM_OE_IDLE  = 1'b1;
  localparam logic SRAM_ZZ_IDLE  = 1'b0;
  localparam logic SRAM_SEM_IDLE = 1'b1;
  localparam logic SRAM_RW_IDLE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/gpu_sram_writer_fifo.sv
// Synchronous pixel FIFO. Head entry is readable combinationally whenever the
// FIFO is non-empty, so the writer can pop and latch it in the same cycle.
module gpu_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle
  assign w_push_ok = i_push & !o_full;
  assign w_pop_ok  = i_pop & !o_empty;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{PTR_W{1'b0}}, w_push_ok} - {{PTR_W{1'b0}}, w_pop_ok};
    end
  end

endmodule

// File: rtl/gpu_sram_writer.sv
// Framebuffer SRAM writer: buffers resolved pixels and retires each one as a
// timed SETUP / WRITE / HOLD cycle on the SRAM pins, with backpressure,
// sticky overflow flag and an end-of-frame flush handshake.
module gpu_sram_writer
  import gpu_sram_writer_pkg::*;
#(
  parameter int W_BITS       = WIDTH_BITS,
  parameter int H_BITS       = HEIGHT_BITS,
  parameter int C_BITS       = CHANNEL_BITS,
  parameter int DEPTH        = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pixel_valid_i,
  input  logic [W_BITS-1:0]          x_i,
  input  logic [H_BITS-1:0]          y_i,
  input  logic [C_BITS-1:0]          r_i,
  input  logic [C_BITS-1:0]          g_i,
  input  logic [C_BITS-1:0]          b_i,
  input  logic                       buf_sel_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       busy_o,
  output logic                       overflow_o,
  output logic                       CE0_o,
  output logic                       CE1_o,
  output logic                       R_W_o,
  output logic                       OE_o,
  output logic                       LB_o,
  output logic                       UB_o,
  output logic                       ZZ_o,
  output logic                       SEM_o,
  output logic [3*C_BITS-1:0]        rgbdataout_o,
  output logic [W_BITS+H_BITS:0]     adddataout_o
);

  localparam int ADDR_W  = W_BITS + H_BITS + 1;
  localparam int DATA_W  = 3 * C_BITS;
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_MAX = (SETUP_CYCLES > WRITE_CYCLES) ? SETUP_CYCLES : WRITE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_CYCLES - 1);

  wr_state_e             r_state;
  wr_state_e             w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  r_ce;
  logic                  w_ce_next;
  logic                  r_rw;
  logic                  w_rw_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     w_addr_next;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W-1:0]     w_data_next;

  logic                  r_overflow;
  logic                  r_flush_pending;
  logic                  r_flush_done;

  logic [ENTRY_W-1:0]    w_entry;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_flush_req;
  logic                  w_drained;

  // Entry layout {buf_sel, y, x, r, g, b}: address in the top bits, colour below
  assign w_entry = {buf_sel_i, y_i, x_i, r_i, g_i, b_i};
  assign ready_o = !w_full;
  assign w_push  = pixel_valid_i & !w_full;

  gpu_pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Write-cycle sequencing: computes the next pin values, which are then registered
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    w_ce_next    = r_ce;
    w_rw_next    = r_rw;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_addr_next  = w_head[ENTRY_W-1 -: ADDR_W];
          w_data_next  = w_head[DATA_W-1:0];
          w_ce_next    = 1'b1;
          w_rw_next    = SRAM_RW_IDLE;
          w_cnt_next   = '0;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_rw_next    = 1'b0;
          w_cnt_next   = '0;
          w_state_next = ST_WRITE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_WRITE: begin
        if (r_cnt == WRITE_LAST) begin
          w_rw_next    = SRAM_RW_IDLE;
          w_cnt_next   = '0;
          w_state_next = ST_HOLD;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        // Chip stays selected across back-to-back pixels; only the strobe pulses
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_addr_next  = w_head[ENTRY_W-1 -: ADDR_W];
          w_data_next  = w_head[DATA_W-1:0];
          w_cnt_next   = '0;
          w_state_next = ST_SETUP;
        end else begin
          w_ce_next    = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, cycle counter and registered SRAM pins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ce    <= 1'b0;
      r_rw    <= SRAM_RW_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ce    <= w_ce_next;
      r_rw    <= w_rw_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
    end
  end

  // Flush completes once nothing is buffered, nothing is arriving and the bus is idle
  assign w_flush_req = r_flush_pending | flush_i;
  assign w_drained   = w_empty & (r_state == ST_IDLE) & !w_push;

  // Flush handshake and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_pending <= 1'b0;
      r_flush_done    <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_flush_done    <= w_flush_req & w_drained;
      r_flush_pending <= w_flush_req & !w_drained;
      if (pixel_valid_i & w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign flush_done_o = r_flush_done;
  assign overflow_o   = r_overflow;
  assign busy_o       = (r_state != ST_IDLE) | (w_count != '0);

  assign CE0_o        = !r_ce;
  assign CE1_o        = r_ce;
  assign LB_o         = !r_ce;
  assign UB_o         = !r_ce;
  assign R_W_o        = r_rw;
  assign OE_o         = SRAM_OE_IDLE;
  assign ZZ_o         = SRAM_ZZ_IDLE;
  assign SEM_o        = SRAM_SEM_IDLE;
  assign rgbdataout_o = r_data;
  assign adddataout_o = r_addr;

endmodule

// File: tb/tb_gpu_sram_writer.sv
// Self-checking bench for gpu_sram_writer: table-driven single-pixel writes,
// a cycle-level occupancy model feeding an expected-write queue, and
// hand-written burst / overflow / flush / reset sequences.
module tb_gpu_sram_writer;

  localparam int DEPTH = 8;
  localparam int WRITE_CYCLES = 2;
  localparam int PERIOD = 4;  // setup 1 + write 2 + hold 1

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_valid_i = 1'b0;
  logic [9:0]  x_i = '0;
  logic [8:0]  y_i = '0;
  logic [7:0]  r_i = '0;
  logic [7:0]  g_i = '0;
  logic [7:0]  b_i = '0;
  logic        buf_sel_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_o, flush_done_o, busy_o, overflow_o;
  logic        CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, ZZ_o, SEM_o;
  logic [23:0] rgbdataout_o;
  logic [19:0] adddataout_o;

  gpu_sram_writer dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_valid_i (pixel_valid_i),
    .x_i           (x_i),
    .y_i           (y_i),
    .r_i           (r_i),
    .g_i           (g_i),
    .b_i           (b_i),
    .buf_sel_i     (buf_sel_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .flush_done_o  (flush_done_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .CE0_o         (CE0_o),
    .CE1_o         (CE1_o),
    .R_W_o         (R_W_o),
    .OE_o          (OE_o),
    .LB_o          (LB_o),
    .UB_o          (UB_o),
    .ZZ_o          (ZZ_o),
    .SEM_o         (SEM_o),
    .rgbdataout_o  (rgbdataout_o),
    .adddataout_o  (adddataout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        bs;
    logic [19:0] exp_addr;
    logic [23:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [19:0] addr;
    logic [23:0] data;
  } exp_t;

  vec_t tbl [4];
  exp_t exp_q [$];
  int   fall_q [$];

  int checks = 0;
  int errors = 0;

  // model state
  int cyc = 0;
  int m_count = 0;
  int m_busy = 0;
  int m_ovf = 0;

  // monitor state
  exp_t  mon_e;
  logic  prev_rw = 1'b1;
  logic  prev_ce0 = 1'b1;
  int    rw_run = 0;
  int    ce_run = 0;
  int    last_ce_run = 0;
  int    ce_rises = 0;
  int    ce_rise_cyc = 0;
  int    writes = 0;
  int    done_samples = 0;
  int    done_cyc = 0;
  logic [19:0] cap_addr = '0;
  logic [23:0] cap_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Occupancy / write-slot model: one pop opportunity when idle or in the hold cycle
  initial begin
    int acc;
    int pop;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_count = 0;
        m_busy  = 0;
        m_ovf   = 0;
        exp_q.delete();
      end else begin
        acc = (pixel_valid_i && (m_count < DEPTH)) ? 1 : 0;
        pop = ((m_count > 0) && (m_busy <= 1)) ? 1 : 0;
        if (pixel_valid_i && acc == 0) m_ovf = 1;
        if (acc == 1) exp_q.push_back({buf_sel_i, y_i, x_i, r_i, g_i, b_i});
        m_count = m_count + acc - pop;
        if (pop == 1) m_busy = PERIOD;
        else if (m_busy > 0) m_busy--;
      end
    end
  end

  // Pin monitor: per-cycle flag checks, write capture against the scoreboard, pulse widths
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rw  = 1'b1;
        prev_ce0 = 1'b1;
        rw_run   = 0;
        ce_run   = 0;
      end else begin
        chk("ready", 32'(ready_o), 32'(m_count < DEPTH));
        chk("busy", 32'(busy_o), 32'((m_busy != 0) || (m_count != 0)));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        if (!R_W_o) rw_run++;
        if (!CE0_o) ce_run++;
        if (prev_rw && !R_W_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h required=none", adddataout_o);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(adddataout_o), 32'(mon_e.addr));
            chk("wr_data", 32'(rgbdataout_o), 32'(mon_e.data));
          end
          chk("ce_in_write", 32'({CE0_o, CE1_o, LB_o, UB_o}), 32'(4'b0100));
          cap_addr = adddataout_o;
          cap_data = rgbdataout_o;
          fall_q.push_back(cyc);
          writes++;
        end
        if (!R_W_o || !prev_rw) begin
          chk("addr_stable", 32'(adddataout_o), 32'(cap_addr));
          chk("data_stable", 32'(rgbdataout_o), 32'(cap_data));
        end
        if (!prev_rw && R_W_o) begin
          chk("rw_low_len", 32'(rw_run), 32'(WRITE_CYCLES));
          rw_run = 0;
        end
        if (!prev_ce0 && CE0_o) begin
          last_ce_run = ce_run;
          ce_run      = 0;
          ce_rises++;
          ce_rise_cyc = cyc;
        end
        if (flush_done_o) begin
          done_samples++;
          done_cyc = cyc;
        end
        prev_rw  = R_W_o;
        prev_ce0 = CE0_o;
      end
    end
  end

  task automatic drive_pixel(input logic [9:0] x, input logic [8:0] y, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b, input logic bs);
    @(posedge clk);
    #1;
    pixel_valid_i = 1'b1;
    x_i = x; y_i = y; r_i = r; g_i = g; b_i = b; buf_sel_i = bs;
  endtask

  task automatic end_pixels();
    @(posedge clk);
    #1;
    pixel_valid_i = 1'b0;
  endtask

  task automatic wait_rises(input int target, input int limit, input string name);
    int n = 0;
    while (ce_rises < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(ce_rises >= target), 32'(1));
  endtask

  task automatic wait_writes(input int target, input int limit, input string name);
    int n = 0;
    while (writes < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(writes >= target), 32'(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int base_rises;
    int base_writes;
    int n;

    tbl[0] = '{10'd5,   9'd7,   8'h11, 8'h22, 8'h33, 1'b1, 20'h81C05, 24'h112233};
    tbl[1] = '{10'h3FF, 9'h1FF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 20'h7FFFF, 24'hFFFFFF};
    tbl[2] = '{10'h000, 9'h000, 8'h00, 8'h00, 8'h00, 1'b1, 20'h80000, 24'h000000};
    tbl[3] = '{10'h2AA, 9'h155, 8'hA5, 8'h5A, 8'hC3, 1'b0, 20'h556AA, 24'hA55AC3};

    // ---- reset state ----
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pins", 32'({CE0_o, CE1_o, R_W_o, OE_o, LB_o, UB_o, ZZ_o, SEM_o}), 32'(8'b1011_1101));
    chk("rst_addr", 32'(adddataout_o), 32'(0));
    chk("rst_data", 32'(rgbdataout_o), 32'(0));
    chk("rst_flags", 32'({busy_o, ready_o, overflow_o, flush_done_o}), 32'(4'b0100));
    $display("reset released: pins idle checked");

    // ---- table of single-pixel writes: latency, address/data, CE width ----
    for (int i = 0; i < 4; i++) begin
      base_rises = ce_rises;
      drive_pixel(tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].bs);
      @(posedge clk);
      #1 pixel_valid_i = 1'b0;
      @(negedge clk);
      chk("lat_before", 32'({CE0_o, R_W_o}), 32'(2'b11));
      @(negedge clk);
      chk("lat_setup", 32'({CE0_o, CE1_o, R_W_o}), 32'(3'b011));
      wait_rises(base_rises + 1, 20, "single_timeout");
      chk("tbl_addr", 32'(cap_addr), 32'(tbl[i].exp_addr));
      chk("tbl_data", 32'(cap_data), 32'(tbl[i].exp_data));
      chk("ce_low_len", 32'(last_ce_run), 32'(4));
      $display("single pixel %0d: addr=%h data=%h ce_run=%0d", i, cap_addr, cap_data, last_ce_run);
      idle_cycles(2);
    end

    // ---- burst of 8 consecutive pixels ----
    fall_q.delete();
    base_writes = writes;
    base_rises  = ce_rises;
    for (int i = 0; i < 8; i++) begin
      drive_pixel(10'(16 + i), 9'(32 + i), 8'(i), 8'(8'h40 + i), 8'(8'h80 + i), 1'(i));
    end
    end_pixels();
    wait_writes(base_writes + 8, 100, "burst_timeout");
    wait_rises(base_rises + 1, 20, "burst_ce_timeout");
    for (int k = 1; k < 8 && k < fall_q.size(); k++) begin
      chk("burst_spacing", 32'(fall_q[k] - fall_q[k-1]), 32'(PERIOD));
    end
    chk("burst_writes", 32'(writes - base_writes), 32'(8));
    chk("burst_no_ovf", 32'(overflow_o), 32'(0));
    chk("burst_q_empty", 32'(exp_q.size()), 32'(0));
    $display("burst: %0d writes", writes - base_writes);
    idle_cycles(2);

    // ---- flush after three pushes, second flush absorbed ----
    done_samples = 0;
    base_writes  = writes;
    base_rises   = ce_rises;
    for (int i = 0; i < 3; i++) begin
      drive_pixel(10'(200 + i), 9'(100 + i), 8'h0F, 8'(i), 8'hF0, 1'b0);
    end
    @(posedge clk);
    #1;
    pixel_valid_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    wait_writes(base_writes + 3, 60, "flush_wr_timeout");
    wait_rises(base_rises + 1, 20, "flush_ce_timeout");
    idle_cycles(4);
    chk("flush_done_count", 32'(done_samples), 32'(1));
    chk("flush_done_when", 32'(done_cyc), 32'(ce_rise_cyc + 1));
    $display("flush: done pulses=%0d at cycle %0d, bus idle at %0d", done_samples, done_cyc, ce_rise_cyc);

    // ---- flush while idle and empty ----
    done_samples = 0;
    @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_done", 32'(flush_done_o), 32'(1));
    @(negedge clk);
    chk("idle_flush_pulse", 32'(flush_done_o), 32'(0));
    idle_cycles(2);
    chk("idle_flush_count", 32'(done_samples), 32'(1));
    $display("idle flush: done pulses=%0d", done_samples);

    // ---- overflow: 12 pixels back-to-back ignoring ready ----
    base_writes = writes;
    for (int i = 0; i < 12; i++) begin
      drive_pixel(10'(300 + i), 9'(50 + i), 8'(i * 3), 8'(i * 5), 8'(i * 7), 1'(i));
    end
    end_pixels();
    @(negedge clk);
    chk("ovf_set", 32'(overflow_o), 32'(1));
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_drain", 32'(n < 100), 32'(1));
    chk("ovf_sticky", 32'(overflow_o), 32'(1));
    chk("ovf_writes", 32'(writes - base_writes), 32'(11));
    $display("overflow: %0d of 12 pixels written, overflow=%0b", writes - base_writes, overflow_o);

    // ---- reset in the middle of a write ----
    for (int i = 0; i < 3; i++) begin
      drive_pixel(10'(500 + i), 9'(400 + i), 8'hAA, 8'hBB, 8'hCC, 1'b1);
    end
    end_pixels();
    n = 0;
    while (R_W_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rw_low_seen", 32'(R_W_o), 32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_pins", 32'({CE0_o, R_W_o, LB_o, UB_o}), 32'(4'b1111));
    chk("mid_rst_flags", 32'({busy_o, ready_o, overflow_o}), 32'(3'b010));
    chk("mid_rst_addr", 32'(adddataout_o), 32'(0));
    base_writes = writes;
    idle_cycles(20);
    chk("mid_rst_discard", 32'(writes - base_writes), 32'(0));
    $display("reset mid-write: pins idle, %0d writes after reset", writes - base_writes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
